// File: rtl/instruction_fetch_sequencer.sv
// Instruction fetch sequencer: 64x16 instruction memory, a fetch/hold/advance
// handshake toward a downstream consumer, and PC-update strobes for an
// external program counter.
module instruction_fetch_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  instruction_addr,
  input  logic        load_en,
  input  logic [5:0]  load_addr,
  input  logic [15:0] load_data,
  input  logic        out_ready,
  output logic [15:0] instr_out,
  output logic        instr_valid,
  output logic        PC_enable,
  output logic        jump,
  output logic [7:0]  jump_label,
  output logic [7:0]  pc_increment,
  output logic        halted,
  output logic [7:0]  fetch_count
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HOLD,
    ADVANCE,
    HALTED
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_SKIP = 4'hB;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state, state_next;
  logic [15:0] mem [64];
  logic [3:0]  opcode;
  logic        load_ok;

  assign opcode  = instr_out[15:12];
  assign load_ok = (state == IDLE) || (state == HALTED);

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Fetched instruction register and saturating retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out   <= '0;
      fetch_count <= '0;
    end else begin
      if (state == FETCH) begin
        instr_out <= mem[instruction_addr];
      end
      if ((state == HOLD) && out_ready && (fetch_count != 8'hFF)) begin
        fetch_count <= fetch_count + 8'd1;
      end
    end
  end

  // Next-state logic and state-decoded outputs. Outputs are pure decodes of
  // the reset-cleared state, so reset drops them asynchronously.
  always_comb begin
    state_next   = state;
    instr_valid  = 1'b0;
    PC_enable    = 1'b0;
    jump         = 1'b0;
    jump_label   = '0;
    pc_increment = '0;
    halted       = 1'b0;
    case (state)
      IDLE: begin
        if (run && !load_en) state_next = FETCH;
      end
      FETCH: begin
        state_next = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (out_ready) state_next = (opcode == OP_HALT) ? HALTED : ADVANCE;
      end
      ADVANCE: begin
        PC_enable = 1'b1;
        if (opcode == OP_JMP) begin
          jump       = 1'b1;
          jump_label = {2'b00, instr_out[5:0]};
        end else if (opcode == OP_SKIP) begin
          pc_increment = {2'b00, instr_out[5:0]};
        end
        state_next = run ? FETCH : IDLE;
      end
      HALTED: begin
        halted = 1'b1;
        if (!run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
